// File: rtl/cl_tx_pkg.sv
// Shared constants, types and helpers for the CameraLink 7:1 transmit path.
package cl_tx_pkg;

    localparam int CL_BITS_PER_WORD = 7;
    localparam int CL_LANES         = 4;
    localparam int CL_MAX_LANES     = 16;
    localparam int CL_MAX_BITS      = CL_BITS_PER_WORD * CL_MAX_LANES;

    localparam logic [CL_BITS_PER_WORD-1:0] CL_CLK_PATTERN = 7'b1100011;

    typedef logic [CL_BITS_PER_WORD*CL_LANES-1:0] cl_word_t;

    // Narrower words are zero-extended by the caller so one helper serves any lane count.
    function automatic logic [CL_BITS_PER_WORD-1:0] lane_slice(
        input logic [CL_MAX_BITS-1:0] word,
        input int unsigned            lane
    );
        return word[CL_BITS_PER_WORD*lane +: CL_BITS_PER_WORD];
    endfunction

endpackage

// File: rtl/cl_tx_serializer_7to1_lane_shift7.sv
// 7-bit parallel-load, MSB-first shift register used for every serial lane.
module cl_lane_shift7
    import cl_tx_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [CL_BITS_PER_WORD-1:0] d,
    output logic [CL_BITS_PER_WORD-1:0] q
);

    // NOTE: registers are written with <= so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= {q[CL_BITS_PER_WORD-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/cl_tx_serializer_7to1.sv
// CameraLink 7:1 transmit serializer: valid/ready word intake, single hold slot,
// LANES data shifters plus a clock-lane pattern shifter, all in the bit clock domain.
module cl_tx_serializer_7to1
    import cl_tx_pkg::*;
#(
    parameter int                     LANES       = CL_LANES,
    parameter logic [6:0]             CLK_PATTERN = CL_CLK_PATTERN,
    parameter logic [7*LANES-1:0]     IDLE_WORD   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7*LANES-1:0]   din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [LANES-1:0]     sdata,
    output logic                 sclk_lane,
    output logic                 underflow
);

    localparam logic [2:0] PH_FIRST = 3'd0;
    localparam logic [2:0] PH_LOAD  = 3'd6;

    logic [2:0]         phase;
    logic               load_edge;
    logic               accept;
    logic               hold_full;
    logic               started;
    logic [7*LANES-1:0] hold;
    logic [7*LANES-1:0] load_word;
    logic [CL_MAX_BITS-1:0] load_ext;
    logic [6:0]         lane_q [LANES];
    logic [6:0]         pattern_q;

    assign load_edge = (phase == PH_LOAD);
    assign din_ready = !hold_full || load_edge;
    assign accept    = din_valid && din_ready;
    assign load_word = hold_full ? hold : IDLE_WORD;
    assign load_ext  = CL_MAX_BITS'(load_word);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase     <= PH_LOAD;
            hold_full <= 1'b0;
            started   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            phase     <= load_edge ? PH_FIRST : phase + 3'd1;
            // Uses the pre-edge started, so an accept on this same edge cannot mask the pulse.
            underflow <= load_edge && !hold_full && started;
            if (accept) begin
                hold_full <= 1'b1;
                started   <= 1'b1;
            end else if (load_edge) begin
                hold_full <= 1'b0;
            end
        end
    end

    // NOTE: the hold data needs no reset; hold_full alone decides whether it is ever used.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= din;
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        cl_lane_shift7 u_shift (
            .clk  (clk),
            .rst  (rst),
            .load (load_edge),
            .d    (lane_slice(load_ext, n)),
            .q    (lane_q[n])
        );
        assign sdata[n] = lane_q[n][6];
    end

    cl_lane_shift7 u_clk_shift (
        .clk  (clk),
        .rst  (rst),
        .load (load_edge),
        .d    (CLK_PATTERN),
        .q    (pattern_q)
    );

    assign sclk_lane = pattern_q[6];

endmodule

// File: tb/tb_cl_tx_serializer_7to1.sv
// Directed bench for cl_tx_serializer_7to1: outputs are captured every cycle and
// compared against hand-derived word/bit sequences.
module tb_cl_tx_serializer_7to1;
    import cl_tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    cl_word_t   din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] sdata;
    logic       sclk_lane;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tb_p    = 6;
    int base;
    int sbase;
    int r;

    logic [6:0] clk_pat = 7'b1100011;
    logic [6:0] wv;

    logic [3:0] cap_sdata [0:1023];
    logic       cap_sclk  [0:1023];
    logic       cap_uf    [0:1023];

    cl_tx_serializer_7to1 dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sdata     (sdata),
        .sclk_lane (sclk_lane),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock edge; outputs captured at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        tb_p = rst ? 6 : ((tb_p == 6) ? 0 : tb_p + 1);
        if (cyc < 1024) begin
            cap_sdata[cyc] = sdata;
            cap_sclk[cyc]  = sclk_lane;
            cap_uf[cyc]    = underflow;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Seven captured cycles starting at b0 must carry word w, MSB first per lane.
    task automatic check_word(input int b0, input cl_word_t w, input logic uf0);
        logic [3:0] exp_sd;
        for (int b = 0; b < 7; b++) begin
            for (int n = 0; n < 4; n++) exp_sd[n] = w[7*n + 6 - b];
            check($sformatf("sdata c%0d", b0 + b), 32'(cap_sdata[b0 + b]), 32'(exp_sd));
            check($sformatf("sclk c%0d", b0 + b), 32'(cap_sclk[b0 + b]), 32'(clk_pat[6 - b]));
            check($sformatf("uf c%0d", b0 + b), 32'(cap_uf[b0 + b]), (b == 0) ? 32'(uf0) : 32'(0));
        end
    endtask

    // Step to the cycle before a load edge, checking din_ready stays low while hold is full.
    task automatic wait_load_busy(input string tag);
        while (tb_p != 6) begin
            check({tag, " ready_busy"}, 32'(din_ready), 32'(0));
            step();
        end
        check({tag, " ready_load"}, 32'(din_ready), 32'(1));
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;

        // Reset for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst sdata", 32'(sdata), 32'(0));
            check("rst sclk", 32'(sclk_lane), 32'(0));
            check("rst ready", 32'(din_ready), 32'(1));
            check("rst uf", 32'(underflow), 32'(0));
        end
        rst = 1'b0;

        // Idle after release: clock pattern from the first edge, no underflow.
        steps(14);
        check_word(4, '0, 1'b0);
        check_word(11, '0, 1'b0);

        // Single word accepted on a load edge with hold empty: seven-cycle latency,
        // then an idle word flagged by underflow.
        check("single ready", 32'(din_ready), 32'(1));
        din       = 28'h0000055;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        base = cyc;
        wait_load_busy("single");
        step();
        check("single latency", 32'(cyc - base), 32'(7));
        base = cyc;
        steps(13);
        check_word(base, 28'h0000055, 1'b0);
        check_word(base + 7, '0, 1'b1);

        // Streaming 20 words back to back, each lane carrying the word index.
        step();
        wv = 7'd1;
        din       = {4{wv}};
        din_valid = 1'b1;
        check("stream ready first", 32'(din_ready), 32'(1));
        step();
        sbase = 0;
        for (int w = 2; w <= 20; w++) begin
            wv  = 7'(w);
            din = {4{wv}};
            wait_load_busy($sformatf("stream w%0d", w));
            step();
            if (w == 2) sbase = cyc;
        end
        din_valid = 1'b0;
        steps(20);
        for (int k = 0; k < 20; k++) begin
            wv = 7'(k + 1);
            check_word(sbase + 7*k, {4{wv}}, 1'b0);
        end
        check_word(sbase + 140, '0, 1'b1);

        // Word A held, word B accepted on the same load edge that launches A.
        step();
        din       = 28'hABCDEF1;
        din_valid = 1'b1;
        step();
        din = 28'h5A5A5A5;
        wait_load_busy("ab");
        step();
        din_valid = 1'b0;
        base = cyc;
        steps(20);
        check_word(base, 28'hABCDEF1, 1'b0);
        check_word(base + 7, 28'h5A5A5A5, 1'b0);
        check_word(base + 14, '0, 1'b1);

        // Reset at phase 3 while a word is held: held word is dropped, started cleared.
        step();
        din       = 28'h7F00001;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        while (tb_p != 3) step();
        rst = 1'b1;
        step();
        r = cyc;
        check("midrst sdata", 32'(sdata), 32'(0));
        check("midrst sclk", 32'(sclk_lane), 32'(0));
        check("midrst uf", 32'(underflow), 32'(0));
        check("midrst ready", 32'(din_ready), 32'(1));
        rst = 1'b0;
        steps(21);
        check_word(r + 1, '0, 1'b0);
        check_word(r + 8, '0, 1'b0);
        check_word(r + 15, '0, 1'b0);

        // Fresh word after the mid-word reset restarts normal operation.
        check("post ready", 32'(din_ready), 32'(1));
        din       = 28'h1234567;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        base = cyc;
        steps(20);
        check_word(base, '0, 1'b0);
        check_word(base + 7, 28'h1234567, 1'b0);
        check_word(base + 14, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cl_tx_serializer_7to1.md
Name: cl_tx_serializer_7to1

Overview:
- 7:1 transmit serializer for the CameraLink output path.
- Takes 28-bit parallel pixel words (4 data lanes × 7 bits) over a valid/ready handshake. Produces 4 serial data bits plus the CameraLink clock-lane bit, one bit per clock.
- Runs entirely in the serial bit clock domain.
- Each output drives the I input of a differential output buffer (one per lane, 5 total).

Parameters:
- LANES, 4, number of serial data lanes; din width is 7*LANES.
- CLK_PATTERN, 7'b1100011, clock-lane bit sequence per word, sent MSB first.
- IDLE_WORD, 28'h0, word transmitted when no data is held at a load edge.

Ports:
- clk  input  1  serial bit clock; one output bit per lane per cycle.
- rst  input  1  synchronous, active-high reset.
- din  input  7*LANES  parallel word; lane n uses din[7n+6:7n].
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept din this cycle.
- sdata  output  LANES  serial data bits, one per lane, flop outputs.
- sclk_lane  output  1  clock-lane serial bit, flop output.
- underflow  output  1  one-cycle pulse when IDLE_WORD is loaded after streaming has started.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State:
  - phase counter p, 0..6.
  - hold register plus hold_full flag.
  - per-lane 7-bit shift registers.
  - 7-bit clock-pattern shift register.
  - started flag.
- Reset (rst=1 at an edge):
  - p<=6, hold_full<=0, started<=0.
  - All shift registers and the pattern register <=0.
  - underflow<=0.
  - Hence sdata=0 and sclk_lane=0 during reset.
  - din_ready=1 combinationally while hold is empty.
  - rst asserted mid-word discards the held word and the word in flight. No flush.
- Phase counter: p increments each cycle and wraps 6->0. The edge where p==6 is the load edge. The first edge after reset release is a load edge.
- Load edge, per lane:
  - If hold_full: shift_n <= hold lane n.
  - Otherwise: shift_n <= IDLE_WORD lane n.
  - Pattern register <= CLK_PATTERN.
- Non-load edge: all shift registers and the pattern register shift left by 1, filling 0.
- Outputs: sdata[n] = shift_n[6]; sclk_lane = pattern[6]. Bits go out MSB first (din bit 7n+6 first), aligned so the first bit of a word coincides with CLK_PATTERN bit 6.
- Handshake:
  - din_ready = !hold_full || (p==6).
  - Accept when din_valid && din_ready: hold <= din, hold_full <= 1, started <= 1.
- Load edge with hold_full and a simultaneous accept: the old hold goes to the shifter, the new din goes into hold, and hold_full stays 1.
- Load edge with hold_full and no accept: hold_full <= 0.
- Load edge with hold empty:
  - IDLE_WORD is loaded.
  - underflow <= started for exactly one cycle. It reads 1 during the first bit cycle of the idle word.
  - An accept on the same edge is not bypassed; that word goes out at the next load.
- Latency:
  - A word accepted at edge E appears on sdata from the first load edge L > E, then lasts 7 cycles.
  - Worst case L - E = 7. Accepted exactly at a load edge with hold previously empty: L - E = 7.
- Sustained throughput is one word per 7 cycles with no gaps while din_valid is held high.
- din and din_valid must be stable only at accept edges. din_valid may drop without an accept.

Decomposition:
- Package cl_tx_pkg:
  - CL_BITS_PER_WORD = 7, CL_LANES = 4, CL_CLK_PATTERN = 7'b1100011.
  - cl_word_t (28-bit) typedef.
  - Lane slice helper function.
- Sub-module cl_lane_shift7:
  - 7-bit load/shift register with ports clk, rst, load, d[6:0], q.
  - Instantiated LANES+1 times (data lanes and clock lane).
- The top level holds the phase counter, hold register, handshake and underflow logic.

Test Plan:
- Reset: rst=1 for 3 cycles.
  - During reset: sdata=0, sclk_lane=0, din_ready=1, underflow=0.
  - After release: sclk_lane repeats 1,1,0,0,0,1,1 starting the cycle after the first edge. No underflow before any accept.
- Single word: accept din=28'h0000055 (lane0=7'b1010101, others 0). From the next load edge, sdata[0] = 1,0,1,0,1,0,1 aligned with the sclk_lane pattern start; sdata[3:1]=0.
- Streaming: din_valid=1 continuously with words 1,2,3,…,20.
  - Words appear in order, back to back.
  - After hold fills, din_ready is high 1 cycle in 7.
  - underflow never asserts.
- Underflow: accept one word, then din_valid=0. The following load edge emits IDLE_WORD with underflow=1 for exactly one cycle, then 0.
- Simultaneous accept at load edge with hold_full: words A then B.
  - A is shifted out and B is captured on the same edge.
  - B is transmitted at the next load edge.
  - No loss, no duplicate.
- Reset mid-word: assert rst at p=3 while a word is held.
  - Next cycle sdata=0 and sclk_lane=0.
  - After release the held word is not transmitted and underflow does not assert until a new word is accepted.
